int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt aggregator and consumer for peripheral `int_sig_o` lines (timer, uart, gpio, ...).
- Latches up to NUM_SRC source requests through a per-source gateway FSM.
- Presents the highest-priority enabled request to the core on one interrupt line.
- Software uses a claim/complete handshake over the same simple register bus as the other peripherals.

Parameters:
- NUM_SRC, 8, number of interrupt sources, legal range 1..31. Source k has ID k+1; ID 0 means "none".

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low (rst==0 resets)
- src_i  input  NUM_SRC  interrupt requests from peripherals; active-high, synchronous to clk
- data_i  input  32  write data
- addr_i  input  32  register address; only addr_i[4:0] decoded
- we_i  input  1  write enable (`WriteEnable`)
- data_o  output  32  read data, combinational from addr_i
- int_sig_o  output  1  interrupt to core, `INT_ASSERT` while any enabled source is PENDING

Behaviour:
- Registers (offset, access):
  - 0x00 ENABLE, RW: bit k unmasks source k.
  - 0x04 PENDING, RO: bit k = source k in PENDING.
  - 0x08 INFLIGHT, RO: bit k = source k in INFLIGHT.
  - 0x0C CLAIM, read/write.
    - Read returns the ID of the lowest-index source that is both PENDING and enabled, or 0 if none.
    - Write ID performs a claim.
  - 0x10 COMPLETE, WO: write ID performs a complete; reads return 0.
  - Unmapped offsets read 0; writes to them are ignored.
  - ENABLE/PENDING/INFLIGHT bits at NUM_SRC and above read 0.
- Reset (asynchronous, rst low): ENABLE=0, all sources IDLE, edge history=0, int_sig_o deasserted. data_o=0 while rst is low.
- Per-source FSM, updated on posedge clk:
  - IDLE -> PENDING when the source request is high.
  - PENDING -> INFLIGHT on a claim write with the matching ID.
  - INFLIGHT -> IDLE on a complete write with the matching ID.
  - PENDING does not clear when src_i drops; the request stays latched until claimed.
  - INFLIGHT ignores src_i; no re-pend until complete.
  - A source still high at complete goes IDLE on that edge and PENDING on the next edge, so re-assertion is visible 2 cycles after the complete write.
- Disabled sources still go PENDING; ENABLE masks only int_sig_o and the CLAIM read. Disabling a PENDING source leaves it PENDING.
- Claim and complete validity:
  - A claim with ID 0, an out-of-range ID, or an ID not currently PENDING is ignored.
  - A claim of a PENDING but disabled source is legal.
  - A complete of an ID not currently INFLIGHT is ignored.
  - Only the low 5 bits of data_i are used as the ID; bits 31:5 must be 0, otherwise the write is ignored.
- Latency:
  - src_i high before edge N -> PENDING set at edge N -> int_sig_o asserted in the cycle after edge N.
  - int_sig_o is combinational from (PENDING & ENABLE), with no extra register.
  - A claim write at edge N deasserts int_sig_o after edge N if no other enabled source is PENDING.
- Simultaneous events:
  - One bus write per cycle, so claim and complete cannot coincide.
  - A source rising in the same cycle its claim or complete is written follows the FSM rules above.
  - Any number of sources may go PENDING on one edge.
- Multiple INFLIGHT sources are allowed (nested handling); priority is fixed by index only.

Optional Feature:
- INTC_EDGE_TRIG_EN
- When defined:
  - Adds register 0x14 TRIG, RW, reset 0. Bit k=1 makes source k edge-triggered.
  - For edge-triggered sources, the request is (src_i[k] & ~src_q[k]); src_q is a per-source history flop, reset 0, updated every cycle.
  - A rising edge while PENDING or INFLIGHT is dropped.
- When undefined: all sources are level-triggered, offset 0x14 is unmapped (reads 0), and there are no history flops.

Test Plan:
- Reset with src_i=0xFF and rst low -> int_sig_o deasserted, all reads 0. Release rst, ENABLE=0 -> PENDING reads 0xFF, int_sig_o stays low, CLAIM reads 0.
- ENABLE=0x14, pulse src_i[2] and src_i[4] for 1 cycle -> PENDING=0x14, CLAIM reads 3, int_sig_o high. Write CLAIM=3 -> CLAIM reads 5, INFLIGHT=0x04.
- Continuing: write CLAIM=5, then COMPLETE=3 -> int_sig_o low after the CLAIM=5 write, INFLIGHT goes 0x14 then 0x10, PENDING=0.
- Hold src_i[0] high, ENABLE=0x01, claim ID 1, complete ID 1 -> INFLIGHT=0 and PENDING=0 on the edge after complete, PENDING=0x01 one cycle later, int_sig_o re-asserts.
- Illegal ops: CLAIM=0, CLAIM=9 (NUM_SRC=8), CLAIM of an IDLE ID, COMPLETE of a PENDING ID, CLAIM=0x21 -> no state change. Assert rst low mid-INFLIGHT -> immediate clear without waiting for clk.
- With INTC_EDGE_TRIG_EN: TRIG=0x02, ENABLE=0x02, hold src_i[1] high for 10 cycles -> exactly one PENDING. Claim and complete while still high -> no re-pend. Drop and re-raise -> PENDING again.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt aggregator with a per-source gateway FSM
// (IDLE -> PENDING -> INFLIGHT -> IDLE) and a claim/complete register handshake.
// Register map (addr_i[4:0]): 0x00 ENABLE, 0x04 PENDING, 0x08 INFLIGHT,
// 0x0C CLAIM, 0x10 COMPLETE, 0x14 TRIG (only with INTC_EDGE_TRIG_EN).
// Optional feature macro: INTC_EDGE_TRIG_EN adds per-source edge triggering.
module int_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [31:0]        data_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  output logic [31:0]        data_o,
  output logic               int_sig_o
);

  localparam logic [4:0] A_ENABLE   = 5'h00;
  localparam logic [4:0] A_PENDING  = 5'h04;
  localparam logic [4:0] A_INFLIGHT = 5'h08;
  localparam logic [4:0] A_CLAIM    = 5'h0C;
  localparam logic [4:0] A_COMPLETE = 5'h10;
`ifdef INTC_EDGE_TRIG_EN
  localparam logic [4:0] A_TRIG     = 5'h14;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_INFL
  } state_e;

  state_e             state_q [NUM_SRC];
  state_e             state_d [NUM_SRC];
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] enable_d;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] infl;
  logic [NUM_SRC-1:0] req;
  logic [4:0]         reg_off;
  logic [4:0]         wr_id;
  logic               id_ok;
  logic               claim_wr;
  logic               cmpl_wr;
  logic [4:0]         claim_id;
  logic [26:0]        unused_addr;

  assign reg_off     = addr_i[4:0];
  assign unused_addr = addr_i[31:5];
  assign wr_id       = data_i[4:0];

  // An ID write is only meaningful for a clean 5-bit ID naming an existing source
  assign id_ok    = (data_i[31:5] == 27'd0) && (wr_id != 5'd0) &&
                    (wr_id <= 5'(NUM_SRC));
  assign claim_wr = we_i && (reg_off == A_CLAIM) && id_ok;
  assign cmpl_wr  = we_i && (reg_off == A_COMPLETE) && id_ok;

`ifdef INTC_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] trig_q;
  logic [NUM_SRC-1:0] trig_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] src_d;

  // TRIG register update and input history sampled every cycle
  always_comb begin
    trig_d = trig_q;
    src_d  = src_i;
    if (we_i && (reg_off == A_TRIG)) begin
      trig_d = data_i[NUM_SRC-1:0];
    end
  end

  // TRIG and history flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_q <= '0;
      src_q  <= '0;
    end else begin
      trig_q <= trig_d;
      src_q  <= src_d;
    end
  end

  // Edge-triggered sources request only on a 0->1 transition
  assign req = src_i & ~(trig_q & src_q);
`else
  assign req = src_i;
`endif

  // ENABLE register write
  always_comb begin
    enable_d = enable_q;
    if (we_i && (reg_off == A_ENABLE)) begin
      enable_d = data_i[NUM_SRC-1:0];
    end
  end

  // Gateway next state; only a PENDING source can be claimed, only INFLIGHT completed
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        S_IDLE:  if (req[k]) state_d[k] = S_PEND;
        S_PEND:  if (claim_wr && (wr_id == 5'(k + 1))) state_d[k] = S_INFL;
        S_INFL:  if (cmpl_wr && (wr_id == 5'(k + 1))) state_d[k] = S_IDLE;
        default: state_d[k] = S_IDLE;
      endcase
    end
  end

  // Gateway state and enable registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q <= '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        state_q[k] <= S_IDLE;
      end
    end else begin
      enable_q <= enable_d;
      for (int k = 0; k < NUM_SRC; k++) begin
        state_q[k] <= state_d[k];
      end
    end
  end

  // Status vectors and lowest-index pending+enabled ID for the CLAIM read
  always_comb begin
    claim_id = 5'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pend[k] = (state_q[k] == S_PEND);
      infl[k] = (state_q[k] == S_INFL);
    end
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (pend[k] && enable_q[k]) claim_id = 5'(k + 1);
    end
  end

  assign int_sig_o = |(pend & enable_q);

  // Register read mux; forced to zero while reset is held
  always_comb begin
    data_o = 32'd0;
    if (rst) begin
      case (reg_off)
        A_ENABLE:   data_o = 32'(enable_q);
        A_PENDING:  data_o = 32'(pend);
        A_INFLIGHT: data_o = 32'(infl);
        A_CLAIM:    data_o = 32'(claim_id);
`ifdef INTC_EDGE_TRIG_EN
        A_TRIG:     data_o = 32'(trig_q);
`endif
        default:    data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: directed scenarios with literal expectations plus a
// randomized run checked against a bitmask reference model of the gateway rules.
module tb_int_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] src_i;
  logic [31:0]  data_i;
  logic [31:0]  addr_i;
  logic         we_i;
  logic [31:0]  data_o;
  logic         int_sig_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: plain masks
  logic [7:0] m_en, m_pend, m_infl, m_srcq, m_trig;

  typedef struct packed {
    logic [7:0]  src;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [7:0]  pend;
    logic [7:0]  infl;
    logic [4:0]  claim;
    logic        irq;
  } step_t;

  int_ctrl #(.NUM_SRC(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_i     (src_i),
    .data_i    (data_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .data_o    (data_o),
    .int_sig_o (int_sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    addr_i = {27'd0, a};
    #1;
    v = data_o;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    src_i  = '0;
    we_i   = 1'b0;
    data_i = '0;
    addr_i = '0;
    #2;
    rst    = 1'b1;
  endtask

  task automatic drive(input step_t s);
    src_i  = s.src;
    we_i   = s.we;
    addr_i = {27'd0, s.addr};
    data_i = s.data;
    tick();
  endtask

  function automatic void m_reset();
    m_en = '0; m_pend = '0; m_infl = '0; m_srcq = '0; m_trig = '0;
  endfunction

  function automatic int m_claim();
    logic [7:0] x;
    x = m_pend & m_en;
    for (int i = 0; i < 8; i++) if (x[i]) return i + 1;
    return 0;
  endfunction

  // One clock edge of the gateway rules applied to whole masks
  function automatic void m_step(input logic [7:0] s, input logic w,
                                 input logic [4:0] a, input logic [31:0] d);
    logic [7:0] req, np, ni;
    int id;
    bit ok;
    req = s & ~(m_trig & m_srcq);
    np  = m_pend | (req & ~m_pend & ~m_infl);
    ni  = m_infl;
    id  = int'(d[4:0]);
    ok  = (d[31:5] == 27'd0) && (id >= 1) && (id <= N);
    if (w && a == 5'h0C && ok && m_pend[id-1]) begin
      np[id-1] = 1'b0;
      ni[id-1] = 1'b1;
    end
    if (w && a == 5'h10 && ok && m_infl[id-1]) ni[id-1] = 1'b0;
    if (w && a == 5'h00) m_en = d[7:0];
`ifdef INTC_EDGE_TRIG_EN
    if (w && a == 5'h14) m_trig = d[7:0];
`endif
    m_srcq = s;
    m_pend = np;
    m_infl = ni;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0; src_i = 8'hFF; we_i = 1'b0; addr_i = '0; data_i = '0;
    tick(); tick();
    total++; if (int_sig_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", int_sig_o); end
    for (int a = 0; a < 6; a++) begin
      rd(5'(a * 4), v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_read off=%0h got=%h exp=0", a * 4, v); end
    end
    rst = 1'b1;
    tick();
    rd(5'h04, v);
    total++; if (v !== 32'hFF) begin bad++; $display("FAIL reset_pend got=%h exp=000000ff", v); end
    rd(5'h0C, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_claim got=%h exp=0", v); end
    rd(5'h00, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_enable got=%h exp=0", v); end
    total++; if (int_sig_o !== 1'b0) begin bad++; $display("FAIL reset_irq_after got=%b exp=0", int_sig_o); end
    src_i = '0;
  endtask

  task automatic test_priority();
    step_t st [6];
    logic [31:0] v;
    do_reset();
    st = '{
      '{8'h00, 1'b1, 5'h00, 32'h14, 8'h00, 8'h00, 5'd0, 1'b0},
      '{8'h14, 1'b0, 5'h00, 32'h00, 8'h14, 8'h00, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h0C, 32'd3,  8'h10, 8'h04, 5'd5, 1'b1},
      '{8'h00, 1'b1, 5'h0C, 32'd5,  8'h00, 8'h14, 5'd0, 1'b0},
      '{8'h00, 1'b1, 5'h10, 32'd3,  8'h00, 8'h10, 5'd0, 1'b0},
      '{8'h00, 1'b1, 5'h10, 32'd5,  8'h00, 8'h00, 5'd0, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      rd(5'h04, v); total++; if (v !== 32'(st[i].pend)) begin bad++; $display("FAIL prio_pend step=%0d got=%h exp=%h", i, v, st[i].pend); end
      rd(5'h08, v); total++; if (v !== 32'(st[i].infl)) begin bad++; $display("FAIL prio_infl step=%0d got=%h exp=%h", i, v, st[i].infl); end
      rd(5'h0C, v); total++; if (v !== 32'(st[i].claim)) begin bad++; $display("FAIL prio_claim step=%0d got=%0d exp=%0d", i, v, st[i].claim); end
      total++; if (int_sig_o !== st[i].irq) begin bad++; $display("FAIL prio_irq step=%0d got=%b exp=%b", i, int_sig_o, st[i].irq); end
    end
  endtask

  task automatic test_rearm();
    step_t st [6];
    logic [31:0] v;
    do_reset();
    st = '{
      '{8'h01, 1'b1, 5'h00, 32'h01, 8'h01, 8'h00, 5'd1, 1'b1},
      '{8'h01, 1'b1, 5'h0C, 32'd1,  8'h00, 8'h01, 5'd0, 1'b0},
      '{8'h01, 1'b0, 5'h00, 32'd0,  8'h00, 8'h01, 5'd0, 1'b0},
      '{8'h01, 1'b1, 5'h10, 32'd1,  8'h00, 8'h00, 5'd0, 1'b0},
      '{8'h01, 1'b0, 5'h00, 32'd0,  8'h01, 8'h00, 5'd1, 1'b1},
      '{8'h00, 1'b0, 5'h00, 32'd0,  8'h01, 8'h00, 5'd1, 1'b1}
    };
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      rd(5'h04, v); total++; if (v !== 32'(st[i].pend)) begin bad++; $display("FAIL rearm_pend step=%0d got=%h exp=%h", i, v, st[i].pend); end
      rd(5'h08, v); total++; if (v !== 32'(st[i].infl)) begin bad++; $display("FAIL rearm_infl step=%0d got=%h exp=%h", i, v, st[i].infl); end
      rd(5'h0C, v); total++; if (v !== 32'(st[i].claim)) begin bad++; $display("FAIL rearm_claim step=%0d got=%0d exp=%0d", i, v, st[i].claim); end
      total++; if (int_sig_o !== st[i].irq) begin bad++; $display("FAIL rearm_irq step=%0d got=%b exp=%b", i, int_sig_o, st[i].irq); end
    end
  endtask

  task automatic test_illegal();
    step_t st [12];
    logic [31:0] v;
    do_reset();
    st = '{
      '{8'h06, 1'b1, 5'h00, 32'hFF, 8'h06, 8'h00, 5'd2, 1'b1},
      '{8'h00, 1'b1, 5'h0C, 32'd2,  8'h04, 8'h02, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h0C, 32'd0,  8'h04, 8'h02, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h0C, 32'd9,  8'h04, 8'h02, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h0C, 32'd1,  8'h04, 8'h02, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h10, 32'd3,  8'h04, 8'h02, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h0C, 32'h23, 8'h04, 8'h02, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h10, 32'h22, 8'h04, 8'h02, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h04, 32'h00, 8'h04, 8'h02, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h18, 32'h00, 8'h04, 8'h02, 5'd3, 1'b1},
      '{8'h00, 1'b1, 5'h00, 32'h00, 8'h04, 8'h02, 5'd0, 1'b0},
      '{8'h00, 1'b1, 5'h0C, 32'd3,  8'h00, 8'h06, 5'd0, 1'b0}
    };
    for (int i = 0; i < 12; i++) begin
      drive(st[i]);
      rd(5'h04, v); total++; if (v !== 32'(st[i].pend)) begin bad++; $display("FAIL illegal_pend step=%0d got=%h exp=%h", i, v, st[i].pend); end
      rd(5'h08, v); total++; if (v !== 32'(st[i].infl)) begin bad++; $display("FAIL illegal_infl step=%0d got=%h exp=%h", i, v, st[i].infl); end
      rd(5'h0C, v); total++; if (v !== 32'(st[i].claim)) begin bad++; $display("FAIL illegal_claim step=%0d got=%0d exp=%0d", i, v, st[i].claim); end
      total++; if (int_sig_o !== st[i].irq) begin bad++; $display("FAIL illegal_irq step=%0d got=%b exp=%b", i, int_sig_o, st[i].irq); end
    end
    rd(5'h10, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL complete_read got=%h exp=0", v); end
    rd(5'h14, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL trig_read got=%h exp=0", v); end
    rd(5'h18, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", v); end
    // Asynchronous reset mid-INFLIGHT, checked before any clock edge
    rst = 1'b0;
    rd(5'h08, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL async_rst_infl got=%h exp=0", v); end
    rst = 1'b1;
    rd(5'h08, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL async_rst_state got=%h exp=0", v); end
  endtask

`ifdef INTC_EDGE_TRIG_EN
  task automatic test_edge();
    step_t sa [2];
    step_t sb [6];
    logic [31:0] v;
    step_t hold;
    do_reset();
    sa = '{
      '{8'h00, 1'b1, 5'h14, 32'h02, 8'h00, 8'h00, 5'd0, 1'b0},
      '{8'h00, 1'b1, 5'h00, 32'h02, 8'h00, 8'h00, 5'd0, 1'b0}
    };
    for (int i = 0; i < 2; i++) begin
      drive(sa[i]);
      rd(5'h04, v); total++; if (v !== 32'(sa[i].pend)) begin bad++; $display("FAIL edge_setup_pend step=%0d got=%h exp=%h", i, v, sa[i].pend); end
    end
    rd(5'h14, v); total++; if (v !== 32'h02) begin bad++; $display("FAIL edge_trig_read got=%h exp=00000002", v); end
    hold = '{8'h02, 1'b0, 5'h00, 32'd0, 8'h02, 8'h00, 5'd2, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(hold);
      rd(5'h04, v); total++; if (v !== 32'h02) begin bad++; $display("FAIL edge_hold_pend cyc=%0d got=%h exp=00000002", i, v); end
    end
    sb = '{
      '{8'h02, 1'b1, 5'h0C, 32'd2, 8'h00, 8'h02, 5'd0, 1'b0},
      '{8'h02, 1'b1, 5'h10, 32'd2, 8'h00, 8'h00, 5'd0, 1'b0},
      '{8'h02, 1'b0, 5'h00, 32'd0, 8'h00, 8'h00, 5'd0, 1'b0},
      '{8'h02, 1'b0, 5'h00, 32'd0, 8'h00, 8'h00, 5'd0, 1'b0},
      '{8'h00, 1'b0, 5'h00, 32'd0, 8'h00, 8'h00, 5'd0, 1'b0},
      '{8'h02, 1'b0, 5'h00, 32'd0, 8'h02, 8'h00, 5'd2, 1'b1}
    };
    for (int i = 0; i < 6; i++) begin
      drive(sb[i]);
      rd(5'h04, v); total++; if (v !== 32'(sb[i].pend)) begin bad++; $display("FAIL edge_pend step=%0d got=%h exp=%h", i, v, sb[i].pend); end
      rd(5'h08, v); total++; if (v !== 32'(sb[i].infl)) begin bad++; $display("FAIL edge_infl step=%0d got=%h exp=%h", i, v, sb[i].infl); end
      total++; if (int_sig_o !== sb[i].irq) begin bad++; $display("FAIL edge_irq step=%0d got=%b exp=%b", i, int_sig_o, sb[i].irq); end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  s;
    logic        w;
    logic [4:0]  a;
    logic [31:0] d, v;
    int          r;
    do_reset();
    m_reset();
    for (int c = 0; c < 400; c++) begin
      s = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      d = 32'($urandom_range(0, 9));
      case (r)
        0:       begin a = 5'h00; d = 32'($urandom_range(0, 255)); end
        1, 2, 3: a = 5'h0C;
        4, 5, 6: a = 5'h10;
        7:       begin a = 5'h14; d = 32'($urandom_range(0, 255)); end
        8:       begin a = ($urandom_range(0, 1) == 0) ? 5'h04 : 5'h18; d = $urandom; end
        default: begin a = 5'h0C; d = {27'($urandom_range(1, 7)), d[4:0]}; end
      endcase
      src_i  = s;
      we_i   = w;
      addr_i = {27'($urandom), a};
      data_i = d;
      tick();
      m_step(s, w, a, d);
      rd(5'h00, v); total++; if (v !== 32'(m_en)) begin bad++; $display("FAIL rand_enable cyc=%0d got=%h exp=%h", c, v, m_en); end
      rd(5'h04, v); total++; if (v !== 32'(m_pend)) begin bad++; $display("FAIL rand_pend cyc=%0d got=%h exp=%h", c, v, m_pend); end
      rd(5'h08, v); total++; if (v !== 32'(m_infl)) begin bad++; $display("FAIL rand_infl cyc=%0d got=%h exp=%h", c, v, m_infl); end
      rd(5'h0C, v); total++; if (v !== 32'(m_claim())) begin bad++; $display("FAIL rand_claim cyc=%0d got=%0d exp=%0d", c, v, m_claim()); end
      rd(5'h14, v); total++; if (v !== 32'(m_trig)) begin bad++; $display("FAIL rand_trig cyc=%0d got=%h exp=%h", c, v, m_trig); end
      total++; if (int_sig_o !== (|(m_pend & m_en))) begin bad++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", c, int_sig_o, |(m_pend & m_en)); end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_rearm();
    test_illegal();
`ifdef INTC_EDGE_TRIG_EN
    test_edge();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
